ifetch_unit: RTL and testbench

// Instruction-fetch initiator for the LSU ROM. The ROM serves 4-byte reads in the window 0x8000..0xFFFC with one cycle of latency.

---
 rtl/ifetch_unit.sv | 118 +++++++++++
 tb/tb_ifetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: sequential 4-byte ROM reads into a small FIFO,
// presented to the decoder over valid/ready, with redirect flush and window fault.
module ifetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h8000,
    parameter int          DEPTH        = 2,
    parameter logic [15:0] ROM_BASE     = 16'h8000,
    parameter logic [15:0] ROM_LAST     = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] a,
    output logic        re,
    input  logic [7:0]  q0,
    input  logic [7:0]  q1,
    input  logic [7:0]  q2,
    input  logic [7:0]  q3,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fault,
    output logic [15:0] fault_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [15:0] pc;
    } entry_t;

    state_t             state;
    logic [15:0]        pc;
    logic [15:0]        inflight_pc;
    logic               inflight;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               legal;
    logic               pop;
    logic               has_space;
    logic               issue;
    logic               wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign legal       = (pc >= ROM_BASE) && (pc <= ROM_LAST);
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;

    // Credit check counts the word already in flight so the FIFO can never overflow.
    assign has_space = ({1'b0, count} + (CNT_W+1)'(inflight))
                       < ((CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop));
    assign issue     = !rst && (state == RUN) && !redirect && legal && has_space;

    assign a        = pc;
    assign re       = issue;
    assign instr    = mem[rd_ptr].word;
    assign instr_pc = mem[rd_ptr].pc;

    assign wr_en = inflight && !redirect && !rst;

    // NOTE: storage array is deliberately left out of reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= '{word: {q3, q2, q1, q0}, pc: inflight_pc};
    end

    // NOTE: sequential state uses non-blocking assignments so later statements see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 16'd4;
            end
            if (redirect) begin
                pc     <= redirect_pc;
                state  <= RUN;
                fault  <= 1'b0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                if (inflight)
                    wr_ptr <= ptr_inc(wr_ptr);
                count <= count + CNT_W'(inflight) - CNT_W'(pop);
                if (state == RUN && !legal) begin
                    fault    <= 1'b1;
                    fault_pc <= pc;
                    state    <= HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a;
    logic        re;
    logic [7:0]  q0, q1, q2, q3;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fault;
    logic [15:0] fault_pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a(a), .re(re),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fault(fault), .fault_pc(fault_pc)
    );

    // ROM: byte at address x is the low byte of x; data returned the cycle after re.
    function automatic logic [7:0] rom_byte(input logic [15:0] ad);
        return ad[7:0];
    endfunction

    function automatic logic [31:0] rom_word(input logic [15:0] ad);
        return {rom_byte(ad + 16'd3), rom_byte(ad + 16'd2), rom_byte(ad + 16'd1), rom_byte(ad)};
    endfunction

    logic        rom_v = 1'b0;
    logic [15:0] rom_a = '0;
    always @(posedge clk) begin
        rom_v <= re;
        rom_a <= a;
    end
    assign q0 = rom_v ? rom_byte(rom_a)          : 8'hzz;
    assign q1 = rom_v ? rom_byte(rom_a + 16'd1)  : 8'hzz;
    assign q2 = rom_v ? rom_byte(rom_a + 16'd2)  : 8'hzz;
    assign q3 = rom_v ? rom_byte(rom_a + 16'd3)  : 8'hzz;

    // Reference model: architectural PC, fault flag and a queue of fetched words.
    typedef struct {
        logic [31:0] word;
        logic [15:0] pc;
    } m_entry_t;

    m_entry_t    m_fifo[$];
    logic [15:0] m_pc = 16'h8000;
    logic        m_halt = 1'b0;
    logic        m_fault = 1'b0;
    logic [15:0] m_fault_pc = '0;
    logic        m_infl = 1'b0;
    logic [15:0] m_infl_pc = '0;

    function automatic logic m_legal(input logic [15:0] p);
        return p >= 16'h8000 && p <= 16'hFFFC;
    endfunction

    function automatic logic m_issue();
        int pop;
        pop = (m_fifo.size() > 0 && instr_ready) ? 1 : 0;
        return !rst && !m_halt && !redirect && m_legal(m_pc)
               && (m_fifo.size() + int'(m_infl) - pop < DEPTH);
    endfunction

    function automatic void model_update();
        logic iss;
        logic pop;
        if (rst) begin
            m_fifo.delete();
            m_pc = 16'h8000; m_halt = 1'b0; m_fault = 1'b0; m_fault_pc = '0; m_infl = 1'b0;
            return;
        end
        iss = m_issue();
        pop = m_fifo.size() > 0 && instr_ready;
        if (pop) void'(m_fifo.pop_front());
        if (redirect) begin
            m_fifo.delete();
            m_infl = 1'b0; m_pc = redirect_pc; m_fault = 1'b0; m_halt = 1'b0;
        end else begin
            if (m_infl) m_fifo.push_back('{word: rom_word(m_infl_pc), pc: m_infl_pc});
            m_infl = iss;
            m_infl_pc = m_pc;
            if (iss) m_pc = m_pc + 16'd4;
            else if (!m_halt && !m_legal(m_pc)) begin
                m_fault = 1'b1; m_fault_pc = m_pc; m_halt = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [15:0] p, input logic y);
        @(negedge clk);
        rst = r; redirect = d; redirect_pc = p; instr_ready = y;
        #1;
    endtask

    task automatic check_model();
        if (rst) begin
            check("re_in_reset", 32'(re), 32'(0));
        end else begin
            check("re", 32'(re), 32'(m_issue()));
            check("a", 32'(a), 32'(m_pc));
            check("instr_valid", 32'(instr_valid), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) begin
                check("instr", instr, m_fifo[0].word);
                check("instr_pc", 32'(instr_pc), 32'(m_fifo[0].pc));
            end
            check("fault", 32'(fault), 32'(m_fault));
            check("fault_pc", 32'(fault_pc), 32'(m_fault_pc));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
    endtask

    task automatic cycle(input logic r, input logic d, input logic [15:0] p, input logic y);
        drive(r, d, p, y);
        check_model();
        advance();
    endtask

    typedef struct {
        logic        rdy;
        logic        rdr;
        logic [15:0] rpc;
        logic        re;
        logic [15:0] a;
        logic        v;
        logic [15:0] pc;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Directed stream after reset: fill, back-pressure, release, redirect.
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'h0000, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h8004, 1'b0, 16'h0000, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h8008, 1'b1, 16'h8000, 32'h03020100};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h800C, 1'b1, 16'h8004, 32'h07060504};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h8010, 1'b1, 16'h8008, 32'h0B0A0908};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h8010, 1'b1, 16'h8008, 32'h0B0A0908};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h8010, 1'b1, 16'h8008, 32'h0B0A0908};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h8014, 1'b1, 16'h800C, 32'h0F0E0D0C};
        tbl[8]  = '{1'b1, 1'b1, 16'h9000, 1'b0, 16'h8018, 1'b1, 16'h8010, 32'h13121110};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h9000, 1'b0, 16'h0000, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h9004, 1'b0, 16'h0000, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h9008, 1'b1, 16'h9000, 32'h03020100};

        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, tbl[i].rdr, tbl[i].rpc, tbl[i].rdy);
            check_model();
            check($sformatf("tbl%0d_re", i), 32'(re), 32'(tbl[i].re));
            check($sformatf("tbl%0d_a", i), 32'(a), 32'(tbl[i].a));
            check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                check($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
                check($sformatf("tbl%0d_instr", i), instr, tbl[i].word);
            end
            advance();
        end

        // Last legal word, then PC overflows to 0000 and faults.
        cycle(1'b0, 1'b1, 16'hFFFC, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        check_model();
        check("ovf_fault", 32'(fault), 32'(1));
        check("ovf_fault_pc", 32'(fault_pc), 32'(16'h0000));
        check("ovf_re", 32'(re), 32'(0));
        check("ovf_valid", 32'(instr_valid), 32'(1));
        check("ovf_last_pc", 32'(instr_pc), 32'(16'hFFFC));
        check("ovf_last_instr", instr, 32'hFFFEFDFC);
        advance();
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b1, 16'h8000, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        check_model();
        check("resume_fault", 32'(fault), 32'(0));
        check("resume_re", 32'(re), 32'(1));
        check("resume_a", 32'(a), 32'(16'h8000));
        advance();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect just below the window.
        cycle(1'b0, 1'b1, 16'h7FFE, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        check_model();
        check("low_re", 32'(re), 32'(0));
        advance();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        check_model();
        check("low_fault", 32'(fault), 32'(1));
        check("low_fault_pc", 32'(fault_pc), 32'(16'h7FFE));
        check("low_valid", 32'(instr_valid), 32'(0));
        advance();

        // Reset with a queued word and a word in flight.
        cycle(1'b0, 1'b1, 16'hA000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        check_model();
        check("rst_valid", 32'(instr_valid), 32'(0));
        check("rst_fault", 32'(fault), 32'(0));
        check("rst_re", 32'(re), 32'(1));
        check("rst_a", 32'(a), 32'(16'h8000));
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, d, y;
            logic [15:0] p;
            r = ($urandom_range(0, 199) == 0);
            d = ($urandom_range(0, 19) == 0);
            y = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       p = 16'h8000 | (16'($urandom) & 16'h7FFC);
                1:       p = 16'hFFF0 + 16'($urandom_range(0, 15));
                2:       p = 16'($urandom) & 16'h7FFF;
                default: p = 16'h8000 | 16'($urandom);
            endcase
            cycle(r, d, p, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
